// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the instruction fetch stage and its helper block.
//   fetch_state_e    : fetch FSM states (S_REQ waits on memory, S_HOLD
//                      presents a word to decode)
//   OPCODE_HI/LO     : bit range of the primary opcode inside a word
//   IMM_W            : width of the branch immediate field
//   DEFAULT_RESET_PC : PC loaded on reset unless the top overrides it
//   opcode_of()      : extracts the opcode field from an instruction word
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;
    localparam int IMM_W     = 16;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_HI:OPCODE_LO];
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// ---------------------------------------------------------------------------
// branch_target_calc
// Purely combinational branch target adder.
//   pc_plus4 [31:0]   in  : address of the instruction after the branch
//   imm16    [IMM_W-1:0] in : signed word offset from the instruction
//   target   [31:0]   out : pc_plus4 + (sign_extend(imm16) << 2), mod 2^32
// ---------------------------------------------------------------------------
module branch_target_calc
    import mips_pkg::*;
(
    input  logic [31:0]      pc_plus4,
    input  logic [IMM_W-1:0] imm16,
    output logic [31:0]      target
);

    logic [31:0] byte_offset;

    // Word offset becomes a byte offset: sign-extend into the upper bits and
    // append two zero bits for the shift by 2.
    assign byte_offset = {{(32 - IMM_W - 2){imm16[IMM_W-1]}}, imm16, 2'b00};

    // Carry out of bit 31 is dropped, so wrap-around is silent.
    assign target = pc_plus4 + byte_offset;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding the main control decoder. Holds the PC,
// fetches one word at a time over a req/ready handshake, and presents the
// captured word to decode until it is accepted. On acceptance the PC moves
// to pc+4, or to the branch target when branch & zero.
//   clk         in  : single clock, rising edge
//   reset       in  : synchronous, active-high
//   imem_req    out : fetch request to instruction memory
//   imem_addr   out : byte address of the requested word (= pc)
//   imem_ready  in  : memory response valid this cycle
//   imem_rdata  in  : returned instruction word
//   inst        out : captured instruction
//   opcode      out : inst[31:26]
//   inst_valid  out : inst/opcode/pc/pc_plus4 valid for decode
//   inst_accept in  : decode consumes the current instruction
//   branch      in  : branch flag for the current instruction
//   zero        in  : ALU zero flag for the current instruction
//   pc          out : address of the current instruction
//   pc_plus4    out : pc + 4
// ---------------------------------------------------------------------------
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         inst,
    output logic [OPCODE_W-1:0] opcode,
    output logic                inst_valid,
    input  logic                inst_accept,
    input  logic                branch,
    input  logic                zero,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4
);

    fetch_state_e state;
    fetch_state_e next_state;

    logic [31:0] target;
    logic        capture;
    logic        advance;
    logic        taken;

    // Only one request is ever in flight, so a redirect never has a younger
    // fetch to squash.
    assign capture = (state == S_REQ)  && imem_ready;
    assign advance = (state == S_HOLD) && inst_accept;
    assign taken   = branch && zero;

    assign pc_plus4 = pc + 32'd4;
    assign opcode   = opcode_of(inst);

    branch_target_calc u_target (
        .pc_plus4 (pc_plus4),
        .imm16    (inst[IMM_W-1:0]),
        .target   (target)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: wait for memory, then wait for decode.
    always_comb begin
        next_state = state;
        unique case (state)
            S_REQ:   if (imem_ready)  next_state = S_HOLD;
            S_HOLD:  if (inst_accept) next_state = S_REQ;
            default: next_state = S_REQ;
        endcase
    end

    // Output decode. Reset gates the handshakes off combinationally so that
    // nothing is requested or presented during any reset cycle.
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        if (!reset) begin
            imem_req   = (state == S_REQ);
            inst_valid = (state == S_HOLD);
        end
    end

    assign imem_addr = pc;

    // PC and instruction registers. A response landing in a reset cycle is
    // dropped because reset takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc   <= RESET_PC;
            inst <= '0;
        end else begin
            if (capture) begin
                inst <= imem_rdata;
            end
            if (advance) begin
                pc <= taken ? target : pc_plus4;
            end
        end
    end

endmodule
